// File: rtl/sequenciador_servos_pkg.sv
// Shared definitions for the servo-move sequencer: FSM state codes (which
// double as the db_estado encoding) and the channel-index width helper.
package sequenciador_servos_pkg;

    // State codes; the numeric value is what db_estado shows.
    typedef enum logic [2:0] {
        EST_IDLE  = 3'b000,
        EST_GRANT = 3'b001,
        EST_SHIFT = 3'b010,
        EST_PULSE = 3'b011,
        EST_WAIT  = 3'b100,
        EST_DONE  = 3'b101
    } estado_t;

    // Channel index width: at least one bit even for a single channel.
    function automatic int calc_ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sequenciador_servos_if.sv
// Bus between the main control unit (master) and the servo sequencer (slave).
//
// Handshake: move[i] is a level request from the master for channel i; it is
// sampled on rising clock edges and needs no acknowledge. The slave answers a
// served request with pronto[i] high for exactly one cycle; there is no
// back-pressure, so the master must accept pronto in the cycle it appears.
// gira/shifta are the per-channel drive strobes toward the servo datapaths.
interface sequenciador_servos_if #(
    parameter int N_SERVOS = 3,
    parameter int TIMER_W  = 24
) ();
    import sequenciador_servos_pkg::*;

    localparam int CH_W = calc_ch_w(N_SERVOS);

    logic [N_SERVOS-1:0] move;
    logic [TIMER_W-1:0]  duracao;
    logic [N_SERVOS-1:0] gira;
    logic [N_SERVOS-1:0] shifta;
    logic [N_SERVOS-1:0] pronto;
    logic                ocupado;
    logic [CH_W-1:0]     canal;
    logic [2:0]          db_estado;

    modport master (
        output move, duracao,
        input  gira, shifta, pronto, ocupado, canal, db_estado
    );

    modport slave (
        input  move, duracao,
        output gira, shifta, pronto, ocupado, canal, db_estado
    );

endinterface

// File: rtl/sequenciador_servos_timer.sv
// Settle timer for one servo move: loadable down-counter that never wraps.
// A load of 0 becomes 1 and the count stops at 1, so fim (count==1) is
// always reached and then held until the next clear or load.
module sequenciador_servos_timer #(
    parameter int TIMER_W = 24
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               carrega,
    input  logic [TIMER_W-1:0] valor,
    input  logic               conta,
    input  logic               zera,
    output logic               fim
);

    logic [TIMER_W-1:0] contagem;

    // Counter register: clear, load (0 -> 1) or saturating decrement.
    always_ff @(posedge clock) begin
        if (!reset_n || zera) begin
            contagem <= '0;
        end else if (carrega) begin
            contagem <= (valor == '0) ? TIMER_W'(1) : valor;
        end else if (conta && (contagem > TIMER_W'(1))) begin
            contagem <= contagem - TIMER_W'(1);
        end
    end

    assign fim = (contagem == TIMER_W'(1));

endmodule

// File: rtl/sequenciador_servos.sv
// N-channel servo-move sequencer. Grants one channel at a time, drives its
// pulse (gira) or shift (shifta) strobe, times the move and returns pronto.
//
// Build option SEQUENCIADOR_SERVOS_FILA_EN: when defined, requests are queued
// in a pending register and served round-robin; when undefined, move is only
// looked at in IDLE with fixed priority (lowest index wins).
module sequenciador_servos
    import sequenciador_servos_pkg::*;
#(
    parameter int                  N_SERVOS  = 3,
    parameter int                  TIMER_W   = 24,
    parameter logic [N_SERVOS-1:0] MODE_MASK = 3'b001
) (
    input logic                 clock,
    input logic                 reset_n,
    sequenciador_servos_if.slave bus
);

    localparam int CH_W = calc_ch_w(N_SERVOS);

    estado_t             estado;
    estado_t             prox;
    logic                em_idle;
    logic [CH_W-1:0]     canal_q;
    logic [CH_W-1:0]     vencedor;
    logic                tem_pedido;
    logic [N_SERVOS-1:0] pedidos;
    logic [N_SERVOS-1:0] bit_canal;
    logic                fim;

    // Illegal codes (11x) behave exactly like IDLE.
    assign em_idle   = !(estado inside {EST_GRANT, EST_SHIFT, EST_PULSE, EST_WAIT, EST_DONE});
    assign bit_canal = N_SERVOS'(1) << canal_q;

`ifdef SEQUENCIADOR_SERVOS_FILA_EN
    logic [N_SERVOS-1:0] pendente;
    logic [CH_W-1:0]     ultimo;

    // A request arriving in the same cycle as IDLE must be seen immediately,
    // so the live move vector is merged with what was already queued.
    assign pedidos = pendente | bus.move;

    // Round-robin pick: search starts just after the last channel served.
    always_comb begin
        int idx;
        idx        = 0;
        vencedor   = '0;
        tem_pedido = 1'b0;
        for (int i = 1; i <= N_SERVOS; i++) begin
            idx = int'(ultimo) + i;
            if (idx >= N_SERVOS) begin
                idx = idx - N_SERVOS;
            end
            if (!tem_pedido && pedidos[CH_W'(idx)]) begin
                tem_pedido = 1'b1;
                vencedor   = CH_W'(idx);
            end
        end
    end

    // Pending register and round-robin pointer; a new move wins over the
    // clear of the granted channel so a re-request is never lost.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pendente <= '0;
            ultimo   <= CH_W'(N_SERVOS - 1);
        end else begin
            if (estado == EST_GRANT) begin
                pendente <= (pendente & ~bit_canal) | bus.move;
            end else begin
                pendente <= pendente | bus.move;
            end
            if (em_idle && tem_pedido) begin
                ultimo <= vencedor;
            end
        end
    end
`else
    assign pedidos = bus.move;

    // Fixed priority pick: lowest requesting index wins.
    always_comb begin
        vencedor   = '0;
        tem_pedido = 1'b0;
        for (int i = N_SERVOS - 1; i >= 0; i--) begin
            if (pedidos[CH_W'(i)]) begin
                tem_pedido = 1'b1;
                vencedor   = CH_W'(i);
            end
        end
    end
`endif

    // Granted channel: captured on the IDLE->GRANT edge and held after DONE.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            canal_q <= '0;
        end else if (em_idle && tem_pedido) begin
            canal_q <= vencedor;
        end
    end

    // Settle timer: loaded in GRANT, counts in PULSE/WAIT, cleared in IDLE.
    sequenciador_servos_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .carrega (estado == EST_GRANT),
        .valor   (bus.duracao),
        .conta   ((estado == EST_PULSE) || (estado == EST_WAIT)),
        .zera    (em_idle),
        .fim     (fim)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado <= EST_IDLE;
        end else begin
            estado <= prox;
        end
    end

    // FSM next-state logic.
    always_comb begin
        prox = EST_IDLE;
        case (estado)
            EST_GRANT: prox = MODE_MASK[canal_q] ? EST_PULSE : EST_SHIFT;
            EST_SHIFT: prox = EST_WAIT;
            EST_PULSE: prox = fim ? EST_DONE : EST_PULSE;
            EST_WAIT:  prox = fim ? EST_DONE : EST_WAIT;
            EST_DONE:  prox = EST_IDLE;
            default:   prox = tem_pedido ? EST_GRANT : EST_IDLE;
        endcase
    end

    // FSM outputs, Moore-decoded from state and the granted channel.
    always_comb begin
        bus.gira      = '0;
        bus.shifta    = '0;
        bus.pronto    = '0;
        bus.ocupado   = 1'b1;
        bus.db_estado = 3'b000;
        case (estado)
            EST_GRANT: bus.db_estado = 3'b001;
            EST_SHIFT: begin
                bus.db_estado = 3'b010;
                bus.shifta    = bit_canal;
            end
            EST_PULSE: begin
                bus.db_estado = 3'b011;
                bus.gira      = bit_canal;
            end
            EST_WAIT:  bus.db_estado = 3'b100;
            EST_DONE: begin
                bus.db_estado = 3'b101;
                bus.pronto    = bit_canal;
            end
            default:   bus.ocupado = 1'b0;
        endcase
    end

    assign bus.canal = canal_q;

endmodule

// File: tb/tb_sequenciador_servos.sv
// Self-checking bench for sequenciador_servos (N=3, TIMER_W=8, MODE_MASK=001).
// Honours SEQUENCIADOR_SERVOS_FILA_EN the same way as the design.
module tb_sequenciador_servos;

    localparam int N  = 3;
    localparam int TW = 8;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sequenciador_servos_if #(.N_SERVOS(N), .TIMER_W(TW)) bus ();

    sequenciador_servos #(
        .N_SERVOS  (N),
        .TIMER_W   (TW),
        .MODE_MASK (3'b001)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A move is described by its phase: cycles since the grant edge.
    // Phase 1 is the grant cycle; pulse mode then drives for D cycles and
    // finishes one cycle later, shift mode strobes once, waits D cycles and
    // finishes one cycle later.
    localparam logic [N-1:0] MASK = 3'b001;
    bit       m_busy  = 0;
    int       m_phase = 0;
    int       m_d     = 1;
    int       m_canal = 0;
    int       m_ptr   = N - 1;
    bit [N-1:0] m_pend = '0;

    function automatic int move_len(input int ch, input int d);
        return MASK[ch] ? d + 2 : d + 3;
    endfunction

    always @(posedge clock) begin
        bit [N-1:0] req;
        int pick;
        if (!reset_n) begin
            m_busy  = 0;
            m_canal = 0;
            m_pend  = '0;
            m_ptr   = N - 1;
        end else if (m_busy) begin
            if (m_phase == 1) begin
                m_d = (bus.duracao == 0) ? 1 : int'(bus.duracao);
`ifdef SEQUENCIADOR_SERVOS_FILA_EN
                m_pend[m_canal] = 1'b0;
`endif
            end
            m_phase++;
            if (m_phase > move_len(m_canal, m_d)) m_busy = 0;
`ifdef SEQUENCIADOR_SERVOS_FILA_EN
            m_pend = m_pend | bus.move;
`endif
        end else begin
            req  = bus.move | m_pend;
            pick = -1;
`ifdef SEQUENCIADOR_SERVOS_FILA_EN
            for (int i = 1; i <= N; i++)
                if (pick < 0 && req[(m_ptr + i) % N]) pick = (m_ptr + i) % N;
            m_pend = m_pend | bus.move;
`else
            for (int i = N - 1; i >= 0; i--)
                if (req[i]) pick = i;
`endif
            if (pick >= 0) begin
                m_busy  = 1;
                m_phase = 1;
                m_canal = pick;
                m_ptr   = pick;
            end
        end
    end

    // Compare process: every cycle, all outputs against the model.
    always @(negedge clock) begin
        logic [N-1:0] e_g, e_s, e_p;
        logic [2:0]   e_st;
        e_g = '0; e_s = '0; e_p = '0; e_st = 3'd0;
        if (m_busy) begin
            if (m_phase == 1) e_st = 3'd1;
            else if (MASK[m_canal]) begin
                if (m_phase <= m_d + 1) begin e_st = 3'd3; e_g[m_canal] = 1'b1; end
                else begin e_st = 3'd5; e_p[m_canal] = 1'b1; end
            end else begin
                if (m_phase == 2) begin e_st = 3'd2; e_s[m_canal] = 1'b1; end
                else if (m_phase <= m_d + 2) e_st = 3'd4;
                else begin e_st = 3'd5; e_p[m_canal] = 1'b1; end
            end
        end
        check("ciclo {gira,shifta,pronto,ocupado,canal,db_estado}",
              32'({bus.gira, bus.shifta, bus.pronto, bus.ocupado, bus.canal, bus.db_estado}),
              32'({e_g, e_s, e_p, m_busy, 2'(m_canal), e_st}));
    end

    // ---------------- driver / observer ----------------
    logic [N-1:0] exp_q[$];
    logic [N-1:0] pronto_q[$];
    int           pronto_cyc_q[$];
    int           gira_cnt, gira_first, shift_cnt, shift_first;
    logic [N-1:0] gira_val, shift_val;

    // Start a request at a negedge; the following posedge is edge 0.
    task automatic start_move(input logic [N-1:0] m, input logic [TW-1:0] d);
        @(negedge clock);
        bus.move    = m;
        bus.duracao = d;
    endtask

    // Observe cycles 1..n; drop move at cycle clr_k, optionally pulse inj_val
    // for one cycle at inj_k, optionally scramble duracao after the grant.
    task automatic run_obs(input int n, input int clr_k, input int inj_k,
                           input logic [N-1:0] inj_val, input bit chg_d);
        pronto_q.delete();
        pronto_cyc_q.delete();
        gira_cnt = 0; gira_first = 0; shift_cnt = 0; shift_first = 0;
        gira_val = '0; shift_val = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (bus.gira != 0) begin
                gira_cnt++; gira_val = bus.gira;
                if (gira_first == 0) gira_first = k;
            end
            if (bus.shifta != 0) begin
                shift_cnt++; shift_val = bus.shifta;
                if (shift_first == 0) shift_first = k;
            end
            if (bus.pronto != 0) begin
                pronto_q.push_back(bus.pronto);
                pronto_cyc_q.push_back(k);
            end
            if (k == clr_k) bus.move = '0;
            if (k == inj_k) bus.move = inj_val;
            if (k == inj_k + 1) bus.move = '0;
            if (chg_d && k == 2) bus.duracao = ~bus.duracao;
        end
    endtask

    task automatic check_pronto_order(input string name);
        check({name, " pronto count"}, 32'(pronto_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < pronto_q.size(); i++)
            check({name, " pronto order"}, 32'(pronto_q[i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.move    = 3'b111;
        bus.duracao = '0;
        reset_n     = 1'b0;
        repeat (2) @(negedge clock);
        check("reset gira",      32'(bus.gira),      32'd0);
        check("reset shifta",    32'(bus.shifta),    32'd0);
        check("reset pronto",    32'(bus.pronto),    32'd0);
        check("reset ocupado",   32'(bus.ocupado),   32'd0);
        check("reset canal",     32'(bus.canal),     32'd0);
        check("reset db_estado", 32'(bus.db_estado), 32'd0);
        bus.move = '0;
        reset_n  = 1'b1;
        repeat (2) @(negedge clock);

        // Pulse ch0, D=5; duracao scrambled after GRANT must not matter.
        start_move(3'b001, 8'd5);
        run_obs(10, 1, 0, '0, 1'b1);
        check("pulse gira cycles", 32'(gira_cnt), 32'd5);
        check("pulse gira first",  32'(gira_first), 32'd2);
        check("pulse gira value",  32'(gira_val), 32'b001);
        exp_q.push_back(3'b001);
        if (pronto_cyc_q.size() > 0) check("pulse pronto cycle", 32'(pronto_cyc_q[0]), 32'd7);
        check_pronto_order("pulse");
        check("pulse canal", 32'(bus.canal), 32'd0);

        // Shift ch2, D=0 (treated as 1).
        start_move(3'b100, 8'd0);
        run_obs(8, 1, 0, '0, 1'b0);
        check("shift strobe count", 32'(shift_cnt), 32'd1);
        check("shift strobe cycle", 32'(shift_first), 32'd2);
        check("shift strobe value", 32'(shift_val), 32'b100);
        exp_q.push_back(3'b100);
        if (pronto_cyc_q.size() > 0) check("shift pronto cycle", 32'(pronto_cyc_q[0]), 32'd4);
        check_pronto_order("shift");
        check("shift canal", 32'(bus.canal), 32'd2);

`ifdef SEQUENCIADOR_SERVOS_FILA_EN
        // All three at once, ch1 re-requested during ch0's move.
        start_move(3'b111, 8'd2);
        run_obs(30, 1, 3, 3'b010, 1'b0);
        exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
        check_pronto_order("round robin");
        if (pronto_cyc_q.size() == 3) begin
            check("rr pronto ch0 cycle", 32'(pronto_cyc_q[0]), 32'd4);
            check("rr pronto ch1 cycle", 32'(pronto_cyc_q[1]), 32'd10);
            check("rr pronto ch2 cycle", 32'(pronto_cyc_q[2]), 32'd16);
        end
`else
        // ch1 pulsed while ch0 is busy is dropped.
        start_move(3'b001, 8'd5);
        run_obs(20, 1, 3, 3'b010, 1'b0);
        exp_q.push_back(3'b001);
        check_pronto_order("no-queue drop");
        // Two requests in IDLE: lowest index wins.
        start_move(3'b110, 8'd1);
        run_obs(10, 1, 0, '0, 1'b0);
        exp_q.push_back(3'b010);
        check_pronto_order("no-queue priority");
`endif

        // Reset in the middle of a long pulse.
        start_move(3'b001, 8'd200);
        run_obs(10, 1, 0, '0, 1'b0);
        reset_n = 1'b0;
        @(negedge clock);
        check("midreset gira",      32'(bus.gira),      32'd0);
        check("midreset db_estado", 32'(bus.db_estado), 32'd0);
        check("midreset ocupado",   32'(bus.ocupado),   32'd0);
        reset_n = 1'b1;
        run_obs(30, 0, 0, '0, 1'b0);
        check_pronto_order("midreset");
        check("midreset no gira", 32'(gira_cnt), 32'd0);

        // Random traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            reset_n     = ($urandom_range(0, 149) != 0);
            bus.move    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            bus.duracao = 8'($urandom_range(0, 6));
        end
        @(negedge clock);
        reset_n  = 1'b1;
        bus.move = '0;
        repeat (20) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sequenciador_servos.md
# sequenciador_servos

N-channel servo-move sequencer: accepts per-channel move requests, grants one channel at a time, drives that channel's pulse (`gira`) or shift (`shifta`) strobe, times the move with an internal settle counter and returns a one-cycle `pronto`. It sits between the cube-solving main control unit and the per-servo PWM/position datapaths. It generalises the fixed three-servo manager to N channels, per-channel mode, run-time duration and round-robin arbitration of queued requests.

## Interface
- `N_SERVOS`, 3: number of servo channels (≥1).
- `TIMER_W`, 24: settle-counter width.
- `MODE_MASK`, 3'b001: bit i=1 selects pulse mode for channel i, 0 selects shift mode.
- `CH_W`, derived = max(1, clog2(N_SERVOS)): channel index width.

- `clock`  in  1  single system clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `move`  in  N_SERVOS  per-channel move request, level-sampled.
- `duracao`  in  TIMER_W  move duration in cycles, sampled in GRANT; 0 treated as 1.
- `gira`  out  N_SERVOS  pulse-mode drive, high for the whole move.
- `shifta`  out  N_SERVOS  shift-mode strobe, one cycle.
- `pronto`  out  N_SERVOS  one-cycle completion for the served channel.
- `ocupado`  out  1  high in every state except IDLE.
- `canal`  out  CH_W  channel currently granted (held after DONE).
- `db_estado`  out  3  state code for debug displays.

## Operation
- States: IDLE=000, GRANT=001, SHIFT=010, PULSE=011, WAIT=100, DONE=101; 11x unreachable, decoded as IDLE.
- IDLE: timer cleared. Any eligible request → GRANT.
- GRANT: register winning channel into `canal`; load counter with `duracao` (0→1). → PULSE if `MODE_MASK[canal]`, else SHIFT.
- SHIFT: `shifta[canal]`=1 for one cycle → WAIT.
- PULSE: `gira[canal]`=1; counter decrements; when counter==1 → DONE.
- WAIT: counter decrements; when counter==1 → DONE.
- DONE: `pronto[canal]`=1 for one cycle → IDLE.
- Outputs are Moore-decoded from state and `canal`; at most one bit of `gira`/`shifta`/`pronto` is high at any cycle.
- Counter never wraps: it loads ≥1 and stops decrementing at 1.
- Reset (`reset_n`=0 at a rising edge), including mid-move: state IDLE, all outputs 0, `canal`=0, `db_estado`=000, counter 0, pending register cleared, round-robin pointer = N_SERVOS-1 (channel 0 wins first).

## Timing
- Request sampled in IDLE at edge 0: GRANT in cycle 1.
- Pulse mode, duration D: `gira` high cycles 2..D+1, `pronto` cycle D+2.
- Shift mode, duration D: `shifta` cycle 2, WAIT cycles 3..D+2, `pronto` cycle D+3.
- Back-to-back: after DONE, one IDLE cycle precedes the next GRANT.
- `duracao` changes outside GRANT have no effect on the move in progress.

## Configuration
- `SEQUENCIADOR_SERVOS_FILA_EN` defined: a pending register of N_SERVOS bits captures `move` every cycle (pending |= move). IDLE arbitrates pending bits round-robin, starting at (last served + 1) mod N. GRANT clears the winner's pending bit unless `move` for that channel is high in the same cycle (set wins). Requests arriving while busy are never lost.
- Not defined: no pending register. `move` is sampled only in IDLE, with fixed priority (lowest index wins). Requests deasserted before returning to IDLE are dropped.

## Structure
- Shared package `sequenciador_servos_pkg`: state codes, `db_estado` encoding and the CH_W derivation function.
- Sub-module `sequenciador_servos_timer`: loadable down-counter, TIMER_W wide, with `carrega`, `conta`, `zera` and `fim` (count==1). Arbiter and FSM stay in the top.

## Test plan
Parameters: N=3, TIMER_W=8, MODE_MASK=3'b001.
- Reset: hold `reset_n`=0 two cycles with `move`=3'b111 → all outputs 0, `db_estado`=000, `ocupado`=0.
- Pulse, ch0, `duracao`=5: one-cycle `move`=001 → `gira`=001 for exactly 5 cycles (cycles 2–6), `pronto`=001 at cycle 7, `canal`=0.
- Shift, ch2, `duracao`=0: `move`=100 → `shifta`=100 at cycle 2, one WAIT cycle, `pronto`=100 at cycle 4.
- Round robin (FILA_EN): `move`=111 for one cycle, `duracao`=2 → `pronto` order ch0, ch1, ch2. No extra service, and no loss when ch1 is re-requested mid-move of ch0.
- No-queue (macro off): `move`=010 pulsed during the ch0 move → ch1 never served; `move`=110 held in IDLE → ch1 served first.
- Reset mid-move: `reset_n`=0 during PULSE of ch0 with `duracao`=200 → next cycle `gira`=0, IDLE; pending cleared, so no `pronto` follows.
